// File: rtl/controle_pipeline_pkg.sv
// rtl/controle_pipeline_pkg.sv - shared opcodes, PC source encoding, FSM states and control bundle
package controle_pipeline_pkg;

    localparam int OPCODE_W   = 6;
    localparam int REG_ADDR_W = 5;

    localparam logic [OPCODE_W-1:0] OP_RTYPE   = 6'd0;
    localparam logic [OPCODE_W-1:0] OP_J       = 6'd2;
    localparam logic [OPCODE_W-1:0] OP_JAL     = 6'd3;
    localparam logic [OPCODE_W-1:0] OP_BEQ     = 6'd4;
    localparam logic [OPCODE_W-1:0] OP_BNE     = 6'd5;
    localparam logic [OPCODE_W-1:0] OP_ADDI    = 6'd8;
    localparam logic [OPCODE_W-1:0] OP_ORI     = 6'd13;
    localparam logic [OPCODE_W-1:0] OP_LUI     = 6'd15;
    localparam logic [OPCODE_W-1:0] OP_MFHI    = 6'd16;
    localparam logic [OPCODE_W-1:0] OP_MULTYPE = 6'd28;
    localparam logic [OPCODE_W-1:0] OP_LW      = 6'd35;
    localparam logic [OPCODE_W-1:0] OP_SW      = 6'd43;
    localparam logic [OPCODE_W-1:0] OP_HALT    = 6'd63;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_JUMP   = 2'b01;
    localparam logic [1:0] PC_BRANCH = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    typedef struct packed {
        logic       branch;
        logic       sign_ext;
        logic       reg_write;
        logic       mem_to_reg;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       reg_dst;
        logic       no_dest;
        logic [1:0] pc_src;
        logic       if_flush;
    } ctrl_t;

endpackage

// File: rtl/controle_pipeline_if.sv
// rtl/controle_pipeline_if.sv - ID-stage inputs and control outputs of the pipeline controller
interface controle_pipeline_if;
    import controle_pipeline_pkg::*;

    logic [OPCODE_W-1:0]   opcode;
    logic                  cmp_eq;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  ex_memRead;
    logic [REG_ADDR_W-1:0] ex_rt;

    logic [1:0]            PCsrc;
    logic                  IFflush;
    logic                  branch;
    logic                  signExt;
    logic                  regWrite;
    logic                  memToReg;
    logic                  IorD;
    logic                  memRead;
    logic                  memWrite;
    logic                  ALUsrc;
    logic                  regDst;
    logic                  noDest;
    logic [OPCODE_W-1:0]   opcodeOut;
    logic                  pcWrite;
    logic                  ifidWrite;
    logic                  stall;
    logic                  illegal_op;
    logic                  FIM;

    modport master (
        output opcode, cmp_eq, id_rs, id_rt, ex_memRead, ex_rt,
        input  PCsrc, IFflush, branch, signExt, regWrite, memToReg, IorD, memRead,
               memWrite, ALUsrc, regDst, noDest, opcodeOut, pcWrite, ifidWrite,
               stall, illegal_op, FIM
    );

    modport slave (
        input  opcode, cmp_eq, id_rs, id_rt, ex_memRead, ex_rt,
        output PCsrc, IFflush, branch, signExt, regWrite, memToReg, IorD, memRead,
               memWrite, ALUsrc, regDst, noDest, opcodeOut, pcWrite, ifidWrite,
               stall, illegal_op, FIM
    );

endinterface

// File: rtl/control_decode.sv
// rtl/control_decode.sv - pure combinational opcode to control bundle table
module control_decode
    import controle_pipeline_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                cmp_eq,
    output ctrl_t               ctl,
    output logic                illegal
);

    // Opcode table; branch direction is resolved here from the ID-stage compare
    always_comb begin
        ctl     = '0;
        illegal = 1'b0;
        case (opcode)
            OP_RTYPE, OP_MFHI, OP_MULTYPE: begin
                ctl.reg_write = 1'b1;
                ctl.reg_dst   = 1'b1;
            end
            OP_ADDI, OP_ORI: begin
                ctl.reg_write = 1'b1;
                ctl.alu_src   = 1'b1;
            end
            OP_LUI: begin
                ctl.reg_write = 1'b1;
                ctl.alu_src   = 1'b1;
                ctl.sign_ext  = 1'b1;
            end
            OP_LW: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = 1'b1;
                ctl.ior_d      = 1'b1;
                ctl.mem_read   = 1'b1;
                ctl.alu_src    = 1'b1;
            end
            OP_SW: begin
                ctl.ior_d     = 1'b1;
                ctl.mem_write = 1'b1;
                ctl.alu_src   = 1'b1;
            end
            OP_BEQ: begin
                ctl.branch = 1'b1;
                if (cmp_eq) begin
                    ctl.pc_src   = PC_BRANCH;
                    ctl.if_flush = 1'b1;
                end
            end
            OP_BNE: begin
                ctl.branch = 1'b1;
                if (!cmp_eq) begin
                    ctl.pc_src   = PC_BRANCH;
                    ctl.if_flush = 1'b1;
                end
            end
            OP_J: begin
                ctl.pc_src   = PC_JUMP;
                ctl.if_flush = 1'b1;
            end
            OP_JAL: begin
                ctl.pc_src   = PC_JUMP;
                ctl.if_flush = 1'b1;
                ctl.no_dest  = 1'b1;
            end
            OP_HALT: begin
                ctl = '0;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/controle_pipeline.sv
// rtl/controle_pipeline.sv - ID-stage controller with load-use and multiply interlocks and HALT drain
module controle_pipeline
    import controle_pipeline_pkg::*;
#(
    parameter int MUL_LATENCY  = 4,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic               Clock,
    input  logic               Reset,
    controle_pipeline_if.slave bus
);

    localparam int MUL_W = $clog2(MUL_LATENCY + 1);
    localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);

    state_t           state;
    state_t           state_nxt;
    logic [MUL_W-1:0] mul_cnt;
    logic [DRN_W-1:0] drain_cnt;
    logic [DRN_W-1:0] drain_nxt;

    ctrl_t dec_ctl;
    ctrl_t out_ctl;
    logic  dec_illegal;
    logic  running;
    logic  load_use;
    logic  mul_busy;
    logic  stall;
    logic  bubble;

    control_decode u_decode (
        .opcode  (bus.opcode),
        .cmp_eq  (bus.cmp_eq),
        .ctl     (dec_ctl),
        .illegal (dec_illegal)
    );

    assign running  = (state == ST_RUN);
    assign load_use = bus.ex_memRead && (bus.ex_rt != '0) &&
                      ((bus.ex_rt == bus.id_rs) || (bus.ex_rt == bus.id_rt));
    assign mul_busy = (mul_cnt != '0);
    // Once draining, the ID opcode no longer matters, so no hazard is reported
    assign stall    = running &&
                      (load_use || (mul_busy && ((bus.opcode == OP_MFHI) || (bus.opcode == OP_MULTYPE))));
    // HALT itself issues as a bubble; DRAIN and HALTED bubble everything
    assign bubble   = !running || stall || (bus.opcode == OP_HALT);

    // Multiplier occupancy: reload on an issued MULTYPE, otherwise count down to zero
    always_ff @(posedge Clock) begin
        if (Reset) begin
            mul_cnt <= '0;
        end else if (running && !stall && (bus.opcode == OP_MULTYPE)) begin
            mul_cnt <= MUL_W'(MUL_LATENCY);
        end else if (mul_busy) begin
            mul_cnt <= mul_cnt - 1'b1;
        end
    end

    // FSM state and drain counter registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
        end
    end

    // Next state: the drain holds at its last count until the multiplier is empty
    always_comb begin
        state_nxt = state;
        drain_nxt = drain_cnt;
        case (state)
            ST_RUN: begin
                if ((bus.opcode == OP_HALT) && !stall) begin
                    state_nxt = ST_DRAIN;
                    drain_nxt = DRN_W'(DRAIN_CYCLES);
                end
            end
            ST_DRAIN: begin
                if (drain_cnt > DRN_W'(1)) begin
                    drain_nxt = drain_cnt - 1'b1;
                end else if (!mul_busy) begin
                    state_nxt = ST_HALTED;
                    drain_nxt = '0;
                end
            end
            ST_HALTED: begin
                state_nxt = ST_HALTED;
            end
            default: begin
                state_nxt = ST_RUN;
                drain_nxt = '0;
            end
        endcase
    end

    // Bubble gating of the decoded bundle and the pipeline write enables
    always_comb begin
        out_ctl = '0;
        if (!bubble) begin
            out_ctl = dec_ctl;
        end
    end

    assign bus.branch     = out_ctl.branch;
    assign bus.signExt    = out_ctl.sign_ext;
    assign bus.regWrite   = out_ctl.reg_write;
    assign bus.memToReg   = out_ctl.mem_to_reg;
    assign bus.IorD       = out_ctl.ior_d;
    assign bus.memRead    = out_ctl.mem_read;
    assign bus.memWrite   = out_ctl.mem_write;
    assign bus.ALUsrc     = out_ctl.alu_src;
    assign bus.regDst     = out_ctl.reg_dst;
    assign bus.noDest     = out_ctl.no_dest;
    assign bus.PCsrc      = out_ctl.pc_src;
    assign bus.IFflush    = out_ctl.if_flush;
    assign bus.opcodeOut  = bubble ? '0 : bus.opcode;
    assign bus.pcWrite    = running && !stall;
    assign bus.ifidWrite  = running && !stall;
    assign bus.stall      = stall;
    assign bus.illegal_op = running && dec_illegal;
    assign bus.FIM        = (state == ST_HALTED);

endmodule

// File: tb/tb_controle_pipeline.sv
// tb/tb_controle_pipeline.sv - directed self-checking bench for controle_pipeline
module tb_controle_pipeline;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    controle_pipeline_if bus ();

    controle_pipeline #(.MUL_LATENCY(4), .DRAIN_CYCLES(3)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // {branch,signExt,regWrite,memToReg,IorD,memRead,memWrite,ALUsrc,regDst,noDest}
    function automatic logic [9:0] ctl_vec();
        return {bus.branch, bus.signExt, bus.regWrite, bus.memToReg, bus.IorD,
                bus.memRead, bus.memWrite, bus.ALUsrc, bus.regDst, bus.noDest};
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clock);
            #2;
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic eq, input logic mr,
                         input logic [4:0] ert, input logic [4:0] rs, input logic [4:0] rt);
        bus.opcode     = op;
        bus.cmp_eq     = eq;
        bus.ex_memRead = mr;
        bus.ex_rt      = ert;
        bus.id_rs      = rs;
        bus.id_rt      = rt;
        #1;
    endtask

    typedef struct {
        logic [5:0] op;
        logic       eq;
        logic [9:0] ctl;
        logic [1:0] pcsrc;
        logic       flush;
        logic [5:0] op_out;
    } dec_vec_t;

    dec_vec_t sweep [14] = '{
        '{6'd0,  1'b0, 10'b0010000010, 2'b00, 1'b0, 6'd0},
        '{6'd16, 1'b1, 10'b0010000010, 2'b00, 1'b0, 6'd16},
        '{6'd28, 1'b0, 10'b0010000010, 2'b00, 1'b0, 6'd28},
        '{6'd8,  1'b1, 10'b0010000100, 2'b00, 1'b0, 6'd8},
        '{6'd13, 1'b0, 10'b0010000100, 2'b00, 1'b0, 6'd13},
        '{6'd15, 1'b1, 10'b0110000100, 2'b00, 1'b0, 6'd15},
        '{6'd35, 1'b0, 10'b0011110100, 2'b00, 1'b0, 6'd35},
        '{6'd43, 1'b1, 10'b0000101100, 2'b00, 1'b0, 6'd43},
        '{6'd4,  1'b0, 10'b1000000000, 2'b00, 1'b0, 6'd4},
        '{6'd4,  1'b1, 10'b1000000000, 2'b10, 1'b1, 6'd4},
        '{6'd5,  1'b0, 10'b1000000000, 2'b10, 1'b1, 6'd5},
        '{6'd5,  1'b1, 10'b1000000000, 2'b00, 1'b0, 6'd5},
        '{6'd2,  1'b0, 10'b0000000000, 2'b01, 1'b1, 6'd2},
        '{6'd3,  1'b1, 10'b0000000001, 2'b01, 1'b1, 6'd3}
    };

    initial begin
        drive(6'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        tick(2);

        // Reset state; decode is combinational and follows RUN rules under reset
        check("reset_fim", bus.FIM, 1'b0);
        check("reset_stall", bus.stall, 1'b0);
        check("reset_pcwrite", bus.pcWrite, 1'b1);

        // 1. Decode sweep
        foreach (sweep[i]) begin
            drive(sweep[i].op, sweep[i].eq, 1'b0, 5'd0, 5'd1, 5'd2);
            check($sformatf("dec_ctl_op%0d_eq%0d", sweep[i].op, sweep[i].eq), ctl_vec(), sweep[i].ctl);
            check($sformatf("dec_pcsrc_op%0d_eq%0d", sweep[i].op, sweep[i].eq), bus.PCsrc, sweep[i].pcsrc);
            check($sformatf("dec_flush_op%0d_eq%0d", sweep[i].op, sweep[i].eq), bus.IFflush, sweep[i].flush);
            check($sformatf("dec_opout_op%0d", sweep[i].op), bus.opcodeOut, sweep[i].op_out);
            check($sformatf("dec_illegal_op%0d", sweep[i].op), bus.illegal_op, 1'b0);
        end
        drive(6'd63, 1'b1, 1'b0, 5'd0, 5'd1, 5'd2);
        check("halt_ctl", ctl_vec(), 10'd0);
        check("halt_opout", bus.opcodeOut, 6'd0);
        check("halt_illegal", bus.illegal_op, 1'b0);
        drive(6'd1, 1'b1, 1'b0, 5'd0, 5'd1, 5'd2);
        check("illegal_flag", bus.illegal_op, 1'b1);
        check("illegal_ctl", ctl_vec(), 10'd0);
        check("illegal_pcsrc", bus.PCsrc, 2'b00);

        drive(6'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        tick(1);
        Reset = 1'b0;
        tick(1);

        // 2. Load-use
        drive(6'd8, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0);
        check("lu_stall", bus.stall, 1'b1);
        check("lu_pcwrite", bus.pcWrite, 1'b0);
        check("lu_ifidwrite", bus.ifidWrite, 1'b0);
        check("lu_regwrite", bus.regWrite, 1'b0);
        check("lu_opout", bus.opcodeOut, 6'd0);
        tick(1);
        drive(6'd8, 1'b0, 1'b0, 5'd0, 5'd5, 5'd0);
        check("lu_clear_stall", bus.stall, 1'b0);
        check("lu_clear_regwrite", bus.regWrite, 1'b1);
        drive(6'd8, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0);
        check("lu_rt0_stall", bus.stall, 1'b0);
        drive(6'd8, 1'b0, 1'b1, 5'd7, 5'd1, 5'd7);
        check("lu_rt_match_stall", bus.stall, 1'b1);
        drive(6'd4, 1'b1, 1'b1, 5'd7, 5'd7, 5'd2);
        check("lu_branch_pcsrc", bus.PCsrc, 2'b00);
        check("lu_branch_flush", bus.IFflush, 1'b0);
        tick(1);
        drive(6'd4, 1'b1, 1'b0, 5'd0, 5'd7, 5'd2);
        check("branch_reeval_pcsrc", bus.PCsrc, 2'b10);
        check("branch_reeval_flush", bus.IFflush, 1'b1);
        tick(1);

        // 3. Multiply then MFHI: busy for MUL_LATENCY cycles after issue
        drive(6'd28, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2);
        check("mul_issue_stall", bus.stall, 1'b0);
        check("mul_issue_regwrite", bus.regWrite, 1'b1);
        tick(1);
        drive(6'd16, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("mfhi_stall_c%0d", i), bus.stall, 1'b1);
            check($sformatf("mfhi_pcwrite_c%0d", i), bus.pcWrite, 1'b0);
            check($sformatf("mfhi_regwrite_c%0d", i), bus.regWrite, 1'b0);
            tick(1);
        end
        check("mfhi_issue_stall", bus.stall, 1'b0);
        check("mfhi_issue_regwrite", bus.regWrite, 1'b1);
        check("mfhi_issue_opout", bus.opcodeOut, 6'd16);
        drive(6'd0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2);
        tick(1);

        // Both hazard causes at once still produce one plain stall
        drive(6'd28, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2);
        tick(1);
        drive(6'd16, 1'b0, 1'b1, 5'd3, 5'd3, 5'd2);
        check("both_stall", bus.stall, 1'b1);
        check("both_pcwrite", bus.pcWrite, 1'b0);
        drive(6'd0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2);
        tick(5);

        // 4. Halt drain
        drive(6'd63, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2);
        check("halt_run_pcwrite", bus.pcWrite, 1'b1);
        check("halt_run_fim", bus.FIM, 1'b0);
        tick(1);
        drive(6'd8, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2);
        check("drain_pcwrite", bus.pcWrite, 1'b0);
        check("drain_regwrite", bus.regWrite, 1'b0);
        check("drain_opout", bus.opcodeOut, 6'd0);
        check("drain_fim_e1", bus.FIM, 1'b0);
        tick(2);
        check("drain_fim_e3", bus.FIM, 1'b0);
        tick(1);
        check("halted_fim_e4", bus.FIM, 1'b1);
        tick(10);
        check("halted_fim_sticky", bus.FIM, 1'b1);
        check("halted_pcwrite", bus.pcWrite, 1'b0);
        check("halted_ifidwrite", bus.ifidWrite, 1'b0);

        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;
        check("halted_reset_fim", bus.FIM, 1'b0);
        check("halted_reset_pcwrite", bus.pcWrite, 1'b1);

        // 5. Halt behind a multiply
        drive(6'd28, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2);
        tick(1);
        drive(6'd63, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2);
        tick(1);
        drive(6'd0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2);
        tick(3);
        check("halt_mul_fim_e4", bus.FIM, 1'b0);
        tick(1);
        check("halt_mul_fim_e5", bus.FIM, 1'b1);

        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;

        // 6. Reset mid-drain and mid-multiply
        drive(6'd28, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2);
        tick(1);
        drive(6'd63, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2);
        tick(2);
        check("mid_drain_pcwrite", bus.pcWrite, 1'b0);
        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;
        drive(6'd16, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2);
        check("rst_mid_fim", bus.FIM, 1'b0);
        check("rst_mid_stall", bus.stall, 1'b0);
        check("rst_mid_pcwrite", bus.pcWrite, 1'b1);
        check("rst_mid_regwrite", bus.regWrite, 1'b1);
        check("rst_mid_opout", bus.opcodeOut, 6'd16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
